// File: rtl/spatz_xmem_responder_if.sv
// Bus bundle between the Spatz VLSU x_mem port, the responder and the TCDM-style memory port.
// The responder takes the slave view; the VLSU/memory environment takes the master view.
interface spatz_xmem_responder_if #(
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned BeWidth = DataWidth / 8;

    logic                 x_mem_valid;
    logic                 x_mem_ready;
    logic [IdWidth-1:0]   x_mem_id;
    logic [AddrWidth-1:0] x_mem_addr;
    logic                 x_mem_we;
    logic [2:0]           x_mem_size;
    logic [BeWidth-1:0]   x_mem_be;
    logic [DataWidth-1:0] x_mem_wdata;
    logic                 x_mem_exc;
    logic [5:0]           x_mem_exccode;

    logic                 x_mem_result_valid;
    logic [IdWidth-1:0]   x_mem_result_id;
    logic [DataWidth-1:0] x_mem_result_rdata;
    logic                 x_mem_result_err;

    logic                 mem_req;
    logic                 mem_gnt;
    logic [AddrWidth-1:0] mem_addr;
    logic                 mem_we;
    logic [BeWidth-1:0]   mem_be;
    logic [DataWidth-1:0] mem_wdata;
    logic                 mem_rvalid;
    logic [DataWidth-1:0] mem_rdata;
    logic                 mem_err;

    modport slave (
        input  x_mem_valid, x_mem_id, x_mem_addr, x_mem_we, x_mem_size, x_mem_be, x_mem_wdata,
        output x_mem_ready, x_mem_exc, x_mem_exccode,
        output x_mem_result_valid, x_mem_result_id, x_mem_result_rdata, x_mem_result_err,
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

    modport master (
        output x_mem_valid, x_mem_id, x_mem_addr, x_mem_we, x_mem_size, x_mem_be, x_mem_wdata,
        input  x_mem_ready, x_mem_exc, x_mem_exccode,
        input  x_mem_result_valid, x_mem_result_id, x_mem_result_rdata, x_mem_result_err,
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );
endinterface

// File: rtl/spatz_xmem_responder.sv
// Memory-side responder for one Spatz VLSU X-interface port: alignment check, forwarding to a
// TCDM-style port, and in-order result beats one cycle after each memory response.
module spatz_xmem_responder #(
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    spatz_xmem_responder_if.slave bus
);
    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned SizeMax = $clog2(BeWidth);
    localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);

    logic [AddrWidth-1:0] align_mask;
    logic                 misaligned;
    logic                 full;
    logic                 push;
    logic                 pop;

    logic [MaxOutstanding-1:0][IdWidth-1:0] fifo_id;
    logic [MaxOutstanding-1:0]              fifo_we;
    logic [PtrW-1:0]                        wr_ptr;
    logic [PtrW-1:0]                        rd_ptr;
    logic [CntW-1:0]                        cnt;

    logic                 res_valid;
    logic [IdWidth-1:0]   res_id;
    logic [DataWidth-1:0] res_rdata;
    logic                 res_err;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign align_mask = (AddrWidth'(1) << bus.x_mem_size) - AddrWidth'(1);
    assign misaligned = (32'(bus.x_mem_size) > SizeMax) || ((bus.x_mem_addr & align_mask) != '0);
    // Registered count only: a pop in the same cycle never frees a slot for this cycle's push.
    assign full       = (cnt == CntW'(MaxOutstanding));

    // Outputs are forced quiet while reset is asserted, independent of the clock.
    assign bus.mem_req       = rst_ni & bus.x_mem_valid & ~misaligned & ~full;
    assign bus.x_mem_ready   = rst_ni & (misaligned | (bus.mem_gnt & ~full));
    assign bus.x_mem_exc     = rst_ni & bus.x_mem_valid & misaligned;
    assign bus.x_mem_exccode = bus.x_mem_exc ? (bus.x_mem_we ? 6'd6 : 6'd4) : 6'd0;

    assign bus.mem_addr  = bus.x_mem_addr;
    assign bus.mem_we    = bus.x_mem_we;
    assign bus.mem_be    = bus.x_mem_be;
    assign bus.mem_wdata = bus.x_mem_wdata;

    assign push = bus.mem_req & bus.mem_gnt;
    assign pop  = bus.mem_rvalid & (cnt != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_id <= '0;
            fifo_we <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
        end else begin
            if (push) begin
                fifo_id[wr_ptr] <= bus.x_mem_id;
                fifo_we[wr_ptr] <= bus.x_mem_we;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (!push && pop) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_rdata <= '0;
            res_err   <= 1'b0;
        end else begin
            res_valid <= pop;
            if (pop) begin
                res_id    <= fifo_id[rd_ptr];
                res_rdata <= fifo_we[rd_ptr] ? '0 : bus.mem_rdata;
                res_err   <= bus.mem_err;
            end
        end
    end

    assign bus.x_mem_result_valid = res_valid;
    assign bus.x_mem_result_id    = res_id;
    assign bus.x_mem_result_rdata = res_rdata;
    assign bus.x_mem_result_err   = res_err;

`ifndef SYNTHESIS
    a_exc_needs_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.x_mem_exc |-> bus.x_mem_valid);
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.x_mem_valid && !bus.x_mem_ready) |=>
        $stable({bus.x_mem_id, bus.x_mem_addr, bus.x_mem_we, bus.x_mem_size, bus.x_mem_be, bus.x_mem_wdata}));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !full);
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.mem_rvalid |-> (cnt != '0));
`endif
endmodule

// File: tb/tb_spatz_xmem_responder.sv
// Scoreboard bench for spatz_xmem_responder: driver checks request-side behaviour against a
// queue model, a separate monitor checks every result beat against the expected-result queue.
module tb_spatz_xmem_responder;
    localparam int MAXO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spatz_xmem_responder_if #(.IdWidth(4), .AddrWidth(32), .DataWidth(32)) bus ();

    spatz_xmem_responder #(
        .IdWidth(4), .AddrWidth(32), .DataWidth(32), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct { logic [3:0] id; logic we; } pend_t;
    typedef struct { logic [3:0] id; logic [31:0] rdata; logic err; int due; } exp_t;

    pend_t pend[$];
    exp_t  expq[$];
    int    nchk = 0;
    int    nfail = 0;
    int    cyc = 0;
    bit    acc;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Result monitor, independent of the stimulus process.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.x_mem_result_valid) begin
                if (expq.size() == 0) begin
                    chk("result_unexpected", 1, 0);
                end else begin : pop_blk
                    exp_t e;
                    e = expq.pop_front();
                    chk("result_latency", cyc, e.due);
                    chk("result_id", bus.x_mem_result_id, e.id);
                    chk("result_rdata", bus.x_mem_result_rdata, e.rdata);
                    chk("result_err", bus.x_mem_result_err, e.err);
                end
            end else if (expq.size() > 0 && expq[0].due <= cyc) begin
                chk("result_missing", 0, 1);
                void'(expq.pop_front());
            end
        end
    end

    task automatic step(input bit v, input logic [3:0] id, input logic [31:0] addr, input bit we,
                        input logic [2:0] size, input logic [3:0] be, input logic [31:0] wd,
                        input bit gnt, input bit rv, input logic [31:0] rd, input bit er);
        bit    mis, room, rdy;
        pend_t p;
        @(negedge clk);
        bus.x_mem_valid = v;    bus.x_mem_id = id;     bus.x_mem_addr = addr;
        bus.x_mem_we    = we;   bus.x_mem_size = size; bus.x_mem_be = be;
        bus.x_mem_wdata = wd;   bus.mem_gnt = gnt;     bus.mem_rvalid = rv;
        bus.mem_rdata   = rd;   bus.mem_err = er;
        #1;
        mis  = ((32'd1 << size) > 32'd4) || ((addr & ((32'd1 << size) - 32'd1)) != 32'd0);
        room = pend.size() < MAXO;
        rdy  = 1'b0;
        if (v) begin
            rdy = mis ? 1'b1 : (gnt && room);
            chk("x_mem_ready", bus.x_mem_ready, rdy);
            chk("mem_req", bus.mem_req, !mis && room);
            chk("exc", bus.x_mem_exc, mis);
            chk("exccode", bus.x_mem_exccode, mis ? (we ? 6 : 4) : 0);
            if (!mis && room) begin
                chk("mem_addr", bus.mem_addr, addr);
                chk("mem_we", bus.mem_we, we);
                chk("mem_be", bus.mem_be, be);
                chk("mem_wdata", bus.mem_wdata, wd);
            end
        end else begin
            chk("mem_req_idle", bus.mem_req, 0);
            chk("exc_idle", bus.x_mem_exc, 0);
        end
        if (rv && pend.size() > 0) begin
            p = pend.pop_front();
            expq.push_back('{id: p.id, rdata: (p.we ? 32'd0 : rd), err: er, due: cyc + 1});
        end
        acc = v && rdy;
        if (acc && !mis) pend.push_back('{id: id, we: we});
    endtask

    task automatic idle(input bit rv, input logic [31:0] rd, input bit er);
        step(1'b0, 4'd0, 32'd0, 1'b0, 3'd0, 4'd0, 32'd0, 1'b0, rv, rd, er);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        bus.x_mem_valid = 1'b1; bus.x_mem_addr = 32'h200; bus.x_mem_size = 3'd2;
        bus.x_mem_we = 1'b0;    bus.mem_gnt = 1'b1;      bus.mem_rvalid = 1'b0;
        #1;
        chk("rst_ready", bus.x_mem_ready, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_result_valid", bus.x_mem_result_valid, 0);
        chk("rst_result_id", bus.x_mem_result_id, 0);
        chk("rst_result_rdata", bus.x_mem_result_rdata, 0);
        chk("rst_result_err", bus.x_mem_result_err, 0);
        pend.delete();
        expq.delete();
        repeat (cycles) @(negedge clk);
        bus.x_mem_valid = 1'b0;
        bus.mem_gnt     = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int guard = 0;
        while (pend.size() > 0 && guard < 50) begin
            idle(1'b1, $urandom, 1'(($urandom % 5) == 0));
            guard++;
        end
        idle(1'b0, 32'd0, 1'b0);
        idle(1'b0, 32'd0, 1'b0);
        chk("drain_pending", pend.size(), 0);
        chk("drain_results", expq.size(), 0);
    endtask

    initial begin
        bit          h_v, h_we, h_gnt, h_rv, hold;
        logic [3:0]  h_id, h_be;
        logic [31:0] h_addr, h_wd;
        logic [2:0]  h_size;

        bus.x_mem_valid = 1'b0; bus.x_mem_id = '0;   bus.x_mem_addr = '0; bus.x_mem_we = 1'b0;
        bus.x_mem_size  = '0;   bus.x_mem_be = '0;   bus.x_mem_wdata = '0;
        bus.mem_gnt     = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;

        do_reset(2);

        // Single load, response two cycles after grant.
        step(1, 4'd3, 32'h100, 0, 3'd2, 4'hf, 32'd0, 1, 0, 32'd0, 0);
        idle(0, 32'd0, 0);
        idle(1, 32'hDEADBEEF, 0);
        idle(0, 32'd0, 0);

        // Misaligned store and load are answered at once with exceptions.
        step(1, 4'd5, 32'h102, 1, 3'd2, 4'hf, 32'h1234, 1, 0, 32'd0, 0);
        step(1, 4'd6, 32'h101, 0, 3'd1, 4'h3, 32'd0, 1, 0, 32'd0, 0);
        step(1, 4'd6, 32'h100, 0, 3'd3, 4'hf, 32'd0, 1, 0, 32'd0, 0);
        idle(0, 32'd0, 0);

        // Fill all slots, fifth load stalls; pop in the same cycle must not admit it.
        for (int i = 0; i < MAXO; i++)
            step(1, 4'(8 + i), 32'h200 + 32'(4 * i), 0, 3'd2, 4'hf, 32'd0, 1, 0, 32'd0, 0);
        step(1, 4'd12, 32'h210, 0, 3'd2, 4'hf, 32'd0, 1, 0, 32'd0, 0);
        step(1, 4'd12, 32'h210, 0, 3'd2, 4'hf, 32'd0, 1, 1, 32'h11111111, 0);
        step(1, 4'd12, 32'h210, 0, 3'd2, 4'hf, 32'd0, 1, 0, 32'd0, 0);
        drain();

        // Store then load, back-to-back responses, error on the second.
        step(1, 4'd1, 32'h300, 1, 3'd2, 4'hf, 32'hCAFEF00D, 1, 0, 32'd0, 0);
        step(1, 4'd2, 32'h304, 0, 3'd2, 4'hf, 32'd0, 1, 0, 32'd0, 0);
        idle(1, 32'hAAAA5555, 0);
        idle(1, 32'h12345678, 1);
        idle(0, 32'd0, 0);
        idle(0, 32'd0, 0);

        // Grant withheld for three cycles.
        repeat (3) step(1, 4'd7, 32'h400, 0, 3'd2, 4'hf, 32'd0, 0, 0, 32'd0, 0);
        step(1, 4'd7, 32'h400, 0, 3'd2, 4'hf, 32'd0, 1, 0, 32'd0, 0);
        idle(0, 32'd0, 0);
        chk("single_push", pend.size(), 1);
        idle(1, 32'h0BADCAFE, 0);
        idle(0, 32'd0, 0);

        // Reset with two requests in flight, then normal operation from an empty state.
        step(1, 4'd4, 32'h500, 0, 3'd2, 4'hf, 32'd0, 1, 0, 32'd0, 0);
        step(1, 4'd5, 32'h504, 0, 3'd1, 4'h3, 32'd0, 1, 0, 32'd0, 0);
        do_reset(2);
        for (int i = 0; i < MAXO; i++)
            step(1, 4'(9 + i), 32'h600 + 32'(2 * i), 0, 3'd1, 4'h3, 32'd0, 1, 0, 32'd0, 0);
        drain();

        // Randomized traffic with stall-holding requests.
        hold = 1'b0;
        h_v = 0; h_id = '0; h_addr = '0; h_we = 0; h_size = '0; h_be = '0; h_wd = '0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                h_v    = ($urandom % 3) != 0;
                h_id   = 4'($urandom);
                h_addr = ($urandom & 32'h0000_fff8) | 32'($urandom % 8);
                h_we   = 1'($urandom);
                h_size = 3'($urandom % 4);
                h_be   = 4'($urandom);
                h_wd   = $urandom;
            end
            h_gnt = ($urandom % 4) != 0;
            h_rv  = (pend.size() > 0) && (($urandom % 2) == 0);
            step(h_v, h_id, h_addr, h_we, h_size, h_be, h_wd, h_gnt, h_rv, $urandom,
                 1'(($urandom % 6) == 0));
            hold = h_v && !acc;
        end
        step(h_v, h_id, h_addr, h_we, h_size, h_be, h_wd, 1, 0, 32'd0, 0);
        if (hold && !acc) chk("final_stall_release", 0, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
